// File: rtl/bsg_counter_set_down_one_hot.sv
// One-hot down counter: binary load, single-step decrement with wrap,
// and OR-reduction binary encoding of the registered one-hot state.
module bsg_counter_set_down_one_hot #(
    parameter int max_val_p = 64,
    localparam int lg_els_lp = (max_val_p + 1 > 1) ? $clog2(max_val_p + 1) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 set_i,
    input  logic [lg_els_lp-1:0] val_i,
    input  logic                 down_i,
    output logic [max_val_p:0]   count_r_o,
    output logic [lg_els_lp-1:0] count_bin_o,
    output logic                 zero_o,
    output logic                 wrap_r_o,
    output logic                 set_err_r_o
);

    localparam logic [lg_els_lp:0] max_lp = (lg_els_lp + 1)'(max_val_p);
    localparam logic [max_val_p:0] one_lp = (max_val_p + 1)'(1);

    logic [max_val_p:0]   count_r, count_n, rot;
    logic [lg_els_lp-1:0] sel;
    logic                 over;
    logic                 wrap_r, wrap_n;
    logic                 err_r, err_n;

    // Rotate right: bit 0 wraps to the top; a 1-bit vector stays put.
    if (max_val_p == 0) begin : g_rot_one
        assign rot = count_r;
    end else begin : g_rot_many
        assign rot = {count_r[0], count_r[max_val_p:1]};
    end

    assign over = {1'b0, val_i} > max_lp;
    assign sel  = over ? max_lp[lg_els_lp-1:0] : val_i;

    always_comb begin
        count_n = count_r;
        wrap_n  = 1'b0;
        err_n   = 1'b0;
        if (set_i) begin
            count_n = one_lp << sel;
            err_n   = over;
        end else if (down_i) begin
            count_n = rot;
            wrap_n  = count_r[0];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_r <= one_lp;
            wrap_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            count_r <= count_n;
            wrap_r  <= wrap_n;
            err_r   <= err_n;
        end
    end

    always_comb begin
        count_bin_o = '0;
        for (int i = 0; i <= max_val_p; i++) begin
            count_bin_o = count_bin_o | (count_r[i] ? lg_els_lp'(i) : '0);
        end
    end

    assign count_r_o   = count_r;
    assign zero_o      = count_r[0];
    assign wrap_r_o    = wrap_r;
    assign set_err_r_o = err_r;

    a_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
        $onehot(count_r) && (max_val_p >= 0));

endmodule

// File: tb/tb_bsg_counter_set_down_one_hot.sv
// Bench for bsg_counter_set_down_one_hot: directed table, async reset
// sequences, and randomized run against a modulo-65 integer model.
module tb_bsg_counter_set_down_one_hot;

    localparam int MAX = 64;
    localparam int N   = MAX + 1;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          set_i;
    logic [6:0]    val_i;
    logic          down_i;
    logic [MAX:0]  count_r_o;
    logic [6:0]    count_bin_o;
    logic          zero_o;
    logic          wrap_r_o;
    logic          set_err_r_o;

    int checks = 0;
    int errors = 0;

    int m_cnt;
    bit m_wrap;
    bit m_err;

    bsg_counter_set_down_one_hot #(.max_val_p(MAX)) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .set_i(set_i),
        .val_i(val_i),
        .down_i(down_i),
        .count_r_o(count_r_o),
        .count_bin_o(count_bin_o),
        .zero_o(zero_o),
        .wrap_r_o(wrap_r_o),
        .set_err_r_o(set_err_r_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit       set;
        bit [6:0] val;
        bit       down;
        int       cnt;
        bit       wrap;
        bit       err;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(string nm, logic [MAX:0] act, logic [MAX:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(string tag, int cnt, bit wrap, bit err);
        logic [MAX:0] oh;
        oh = '0;
        oh[cnt] = 1'b1;
        chk({tag, ".count_r"}, count_r_o, oh);
        chk({tag, ".bin"}, (MAX+1)'(count_bin_o), (MAX+1)'(cnt));
        chk({tag, ".zero"}, (MAX+1)'(zero_o), (MAX+1)'(cnt == 0));
        chk({tag, ".wrap"}, (MAX+1)'(wrap_r_o), (MAX+1)'(wrap));
        chk({tag, ".err"}, (MAX+1)'(set_err_r_o), (MAX+1)'(err));
    endtask

    // Model: plain integer count modulo N with saturating load.
    task automatic model_step(bit s, int v, bit d);
        if (s) begin
            m_err  = v > MAX;
            m_cnt  = (v > MAX) ? MAX : v;
            m_wrap = 0;
        end else if (d) begin
            m_wrap = (m_cnt == 0);
            m_cnt  = (m_cnt + N - 1) % N;
            m_err  = 0;
        end else begin
            m_wrap = 0;
            m_err  = 0;
        end
    endtask

    task automatic drive(bit s, bit [6:0] v, bit d);
        set_i  = s;
        val_i  = v;
        down_i = d;
        @(posedge clk_i);
        #1;
        model_step(s, int'(v), d);
    endtask

    task automatic async_reset(string tag);
        #3;
        reset_i = 1'b1;
        #1;
        m_cnt = 0; m_wrap = 0; m_err = 0;
        chk_all(tag, 0, 0, 0);
        set_i = 1'b1; val_i = 7'd9; down_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk_all({tag, ".held"}, 0, 0, 0);
        reset_i = 1'b0;
        set_i = 1'b0; down_i = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1, 7'd5,   0, 5,  0, 0};
        vecs[1]  = '{0, 7'd0,   1, 4,  0, 0};
        vecs[2]  = '{0, 7'd0,   1, 3,  0, 0};
        vecs[3]  = '{0, 7'd0,   1, 2,  0, 0};
        vecs[4]  = '{0, 7'd0,   1, 1,  0, 0};
        vecs[5]  = '{0, 7'd0,   1, 0,  0, 0};
        vecs[6]  = '{0, 7'd0,   1, 64, 1, 0};
        vecs[7]  = '{0, 7'd0,   1, 63, 0, 0};
        vecs[8]  = '{1, 7'd3,   0, 3,  0, 0};
        vecs[9]  = '{1, 7'd10,  1, 10, 0, 0};
        vecs[10] = '{1, 7'd127, 0, 64, 0, 1};
        vecs[11] = '{1, 7'd0,   0, 0,  0, 0};
        vecs[12] = '{0, 7'd0,   0, 0,  0, 0};
        vecs[13] = '{1, 7'd65,  1, 64, 0, 1};
        vecs[14] = '{0, 7'd0,   1, 63, 0, 0};

        reset_i = 1'b1;
        set_i = 0; val_i = '0; down_i = 0;
        m_cnt = 0; m_wrap = 0; m_err = 0;
        repeat (2) @(posedge clk_i);
        #1;
        chk_all("reset", 0, 0, 0);
        reset_i = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].set, vecs[i].val, vecs[i].down);
            chk_all($sformatf("vec%0d", i), vecs[i].cnt,
                    vecs[i].wrap, vecs[i].err);
        end

        // Wrap pulse must last one cycle when the next op is a hold.
        drive(1, 7'd0, 0);
        drive(0, 7'd0, 1);
        chk_all("wrap_pulse", 64, 1, 0);
        drive(0, 7'd0, 0);
        chk_all("wrap_clear", 64, 0, 0);

        drive(1, 7'd40, 0);
        async_reset("mid_reset");
        drive(0, 7'd0, 0);
        chk_all("post_reset", 0, 0, 0);

        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset("rnd_reset");
            end else begin
                drive($urandom_range(0, 3) == 0,
                      7'($urandom_range(0, 127)),
                      $urandom_range(0, 1) == 1);
                chk_all("rnd", m_cnt, m_wrap, m_err);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
